router_term_arbiter: RTL and testbench

Round-robin output arbiter for a router terminal. Shares one output channel among `num_in` first-word-fall-through input FIFOs. Each cycle it selects one pending input, pops it, and holds the package in a single output register. That register is presented downstream with a pending/pop handshake. The block sits between the per-port input FIFOs and the terminal output, using the same `pndng`/`pop` signalling as the terminal interface.

---
 rtl/router_term_arbiter.sv | 139 +++++++++++++
 tb/tb_router_term_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/router_term_arbiter.sv
// Round-robin arbiter that drains several FWFT input FIFOs into one held output
// register, presented downstream with a pending/pop handshake.
module router_term_arbiter #(
    parameter int pckg_sz = 40,
    parameter int num_in  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [num_in*pckg_sz-1:0]     in_data,
    input  logic [num_in-1:0]             in_pndng,
    output logic [num_in-1:0]             in_pop,
    output logic [pckg_sz-1:0]            out_data,
    output logic                          out_pndng,
    input  logic                          out_popin,
    output logic [$clog2(num_in)-1:0]     grant_id,
    output logic [15:0]                   pkt_cnt
);

    localparam int id_w = $clog2(num_in);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    logic [id_w-1:0]     rr_ptr_r;
    logic [id_w-1:0]     grant_id_r;
    logic [pckg_sz-1:0]  out_data_r;
    logic                out_pndng_r;
    logic [15:0]         pkt_cnt_r;

    logic [id_w-1:0]     win_s;
    logic [id_w-1:0]     rr_next_s;
    logic [pckg_sz-1:0]  win_data_s;
    logic                any_req_s;
    logic                load_ok_s;
    logic                grant_s;

    // Find the first pending input at or after rr_ptr, wrapping modulo num_in.
    always_comb begin : search_blk
        logic            found_v;
        logic [id_w:0]   idx_v;
        found_v = 1'b0;
        idx_v   = '0;
        win_s   = '0;
        for (int k = 0; k < num_in; k++) begin
            idx_v = {1'b0, rr_ptr_r} + (id_w+1)'(k);
            if (idx_v >= (id_w+1)'(num_in)) begin
                idx_v = idx_v - (id_w+1)'(num_in);
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && in_pndng[idx_v[id_w-1:0]]) begin
                found_v = 1'b1;
                win_s   = idx_v[id_w-1:0];
            end else begin
                found_v = found_v;
            end
        end
    end

    // Grant qualification; reset gates the pop so no FIFO is drained while in reset.
    always_comb begin
        any_req_s  = |in_pndng;
        load_ok_s  = (state_r == ST_EMPTY) || out_popin;
        grant_s    = !reset && load_ok_s && any_req_s;
        win_data_s = in_data[win_s*pckg_sz +: pckg_sz];
        if (win_s == id_w'(num_in - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_s + id_w'(1);
        end
    end

    // One-hot pop toward the winning input.
    always_comb begin
        in_pop = '0;
        if (grant_s) begin
            in_pop[win_s] = 1'b1;
        end else begin
            in_pop = '0;
        end
    end

    // Output register FSM; a pop and a new grant in the same cycle is a pop-through.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_pndng_r <= 1'b0;
            out_data_r  <= '0;
            grant_id_r  <= '0;
            rr_ptr_r    <= '0;
            pkt_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (grant_s) begin
                        state_r     <= ST_FULL;
                        out_pndng_r <= 1'b1;
                        out_data_r  <= win_data_s;
                        grant_id_r  <= win_s;
                        rr_ptr_r    <= rr_next_s;
                        pkt_cnt_r   <= pkt_cnt_r + 16'd1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_pndng_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (grant_s) begin
                        state_r     <= ST_FULL;
                        out_pndng_r <= 1'b1;
                        out_data_r  <= win_data_s;
                        grant_id_r  <= win_s;
                        rr_ptr_r    <= rr_next_s;
                        pkt_cnt_r   <= pkt_cnt_r + 16'd1;
                    end else if (out_popin) begin
                        state_r     <= ST_EMPTY;
                        out_pndng_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        out_pndng_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_pndng_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_pndng = out_pndng_r;
    assign grant_id  = grant_id_r;
    assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_router_term_arbiter.sv
// Table-driven bench for router_term_arbiter with a scoreboard queue for held packages.
module tb_router_term_arbiter;

    localparam int PW = 40;
    localparam int NI = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI*PW-1:0]  in_data;
    logic [NI-1:0]     in_pndng;
    logic [NI-1:0]     in_pop;
    logic [PW-1:0]     out_data;
    logic              out_pndng;
    logic              out_popin;
    logic [1:0]        grant_id;
    logic [15:0]       pkt_cnt;

    always #5 clk = ~clk;

    router_term_arbiter #(.pckg_sz(PW), .num_in(NI)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_pndng  (in_pndng),
        .in_pop    (in_pop),
        .out_data  (out_data),
        .out_pndng (out_pndng),
        .out_popin (out_popin),
        .grant_id  (grant_id),
        .pkt_cnt   (pkt_cnt)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  pndng;
        logic        popin;
        logic [3:0]  exp_pop;
        logic        exp_pnd;
        logic [1:0]  exp_gid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [PW-1:0] sb[$];
    logic [PW-1:0] held;
    int            checks;
    int            failures;
    int unsigned   seq;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", nm, seq, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] p, input logic pi,
                                input logic [3:0] ep, input logic en,
                                input logic [1:0] eg, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.pndng = p; v.popin = pi; v.exp_pop = ep;
        v.exp_pnd = en; v.exp_gid = eg; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic fill_data();
        for (int i = 0; i < NI; i++) begin
            in_data[i*PW +: PW] = {8'hA5, seq[15:0], 16'(i)};
        end
    endtask

    task automatic apply(input vec_t v);
        reset     = v.rst;
        in_pndng  = v.pndng;
        out_popin = v.popin;
        fill_data();
        #1;
        chk("in_pop", 64'(in_pop), 64'(v.exp_pop));
        if (!v.rst && v.exp_pop != 4'b0000) begin
            for (int i = 0; i < NI; i++) begin
                if (v.exp_pop[i]) sb.push_back(in_data[i*PW +: PW]);
            end
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            sb.delete();
            held = '0;
        end else if (v.exp_pop != 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty step=%0d got=0 expected=1", seq);
            end else begin
                held = sb.pop_front();
            end
        end
        chk("out_pndng", 64'(out_pndng), 64'(v.exp_pnd));
        chk("grant_id",  64'(grant_id),  64'(v.exp_gid));
        chk("pkt_cnt",   64'(pkt_cnt),   64'(v.exp_cnt));
        chk("out_data",  64'(out_data),  64'(held));
        seq++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; seq = 0; held = '0;
        reset = 1'b1; in_pndng = 4'b1111; out_popin = 1'b0;
        fill_data();

        // Reset state, with every input requesting.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_pop",    64'(in_pop),    64'd0);
        chk("rst_out_pndng", 64'(out_pndng), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_grant_id",  64'(grant_id),  64'd0);
        chk("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);

        // Single requester, hold, drain, ignored popin in EMPTY.
        vecs.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'd1));
        // Reset, then fairness with all inputs pending.
        vecs.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd1));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd2));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd3));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'd4));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd5));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd6));
        // Backpressure for five cycles, then release.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'd6));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd7));
        // Reset mid-operation with rr_ptr at 3, first grant afterwards is 0.
        vecs.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 16'd1));
        // Drain to empty, extra pop pulse is ignored.
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd1));
        // Sparse requests skip idle inputs while rotating.
        vecs.push_back(mk(1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd2));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'd3));
        vecs.push_back(mk(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd4));

        foreach (vecs[i]) apply(vecs[i]);

        // Counter wrap: 65536 grants from a clean reset.
        apply(mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0));
        reset = 1'b0; in_pndng = 4'b0001; out_popin = 1'b1;
        for (int n = 0; n < 65536; n++) @(posedge clk);
        #1;
        chk("wrap_pkt_cnt",   64'(pkt_cnt),   64'h0000);
        chk("wrap_out_pndng", 64'(out_pndng), 64'd1);
        @(posedge clk); #1;
        chk("wrap_next_cnt",  64'(pkt_cnt),   64'h0001);
        chk("wrap_grant_id",  64'(grant_id),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
